// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, FSM state type and hex-to-segment table for the display scanner.
// Revision: 1.0
`default_nettype none

package seg_pkg;

  localparam int WORD_W    = 16;
  localparam int FRAME_LEN = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } seg_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; element i is the pattern for hex digit i.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_shift16.sv
// seg_shift16: 16-bit MSB-first load/shift register that emits a latch strobe after the last bit.
// Revision: 1.0
`default_nettype none

module seg_shift16
  import seg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              sdata,
  output logic              latch,
  output logic              done
);

  localparam int BIT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] sreg;
  logic [BIT_W-1:0]  bits_left;
  logic              active;

  // High during the cycle the final bit is on sdata.
  assign done = active && (bits_left == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      bits_left <= '0;
      active    <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
    end else begin
      latch <= 1'b0;
      if (load) begin
        sdata     <= word[WORD_W-1];
        sreg      <= {word[WORD_W-2:0], 1'b0};
        bits_left <= BIT_W'(WORD_W - 1);
        active    <= 1'b1;
      end else if (active) begin
        if (bits_left == '0) begin
          sdata  <= 1'b0;
          latch  <= 1'b1;
          active <= 1'b0;
        end else begin
          sdata     <= sreg[WORD_W-1];
          sreg      <= {sreg[WORD_W-2:0], 1'b0};
          bits_left <= bits_left - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: 4-digit serial seven-segment scan controller (refresh timing, word build, shift-out).
// Optional SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits 3..1. Revision: 1.0
`default_nettype none

module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  output logic        seg_data,
  output logic        seg_latch,
  output logic        frame_busy,
  output logic [1:0]  digit_idx,
  output logic        scan_wrap
);

  localparam int CNT_W = $clog2((REFRESH_DIV > FRAME_LEN) ? REFRESH_DIV : FRAME_LEN);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);

  seg_state_e        state;
  logic [CNT_W-1:0]  refresh_cnt;
  logic              first_frame;
  logic [15:0]       snapshot;
  logic              terminal;
  logic              start;
  logic              shift_done;
  logic [1:0]        next_idx;
  logic [3:0]        nibble;
  logic              blank;
  logic [7:0]        seg_byte;
  logic [7:0]        ctl_byte;
  logic [WORD_W-1:0] word;

  assign terminal = en && (refresh_cnt == TC_VAL);
  // LATCH may hand straight to LOAD so the minimum divider still catches every terminal count.
  assign start    = terminal && ((state == IDLE) || (state == LATCH));
  assign next_idx = first_frame ? 2'd0 : digit_idx + 2'd1;

  always_comb begin
    nibble = 4'h0;
    case (digit_idx)
      2'd0:    nibble = snapshot[3:0];
      2'd1:    nibble = snapshot[7:4];
      2'd2:    nibble = snapshot[11:8];
      default: nibble = snapshot[15:12];
    endcase
  end

`ifdef SEG_BLANK_LEADING_ZERO_EN
  always_comb begin
    blank = 1'b0;
    case (digit_idx)
      2'd3:    blank = (snapshot[15:12] == 4'd0);
      2'd2:    blank = (snapshot[15:8]  == 8'd0);
      2'd1:    blank = (snapshot[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_byte = blank ? SEG_BLANK : hex_to_seg(nibble);
  assign ctl_byte = {4'b0000, 4'b0001 << digit_idx};
  assign word     = {seg_byte, ctl_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
    end else if (!en || terminal) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      digit_idx   <= 2'd0;
      first_frame <= 1'b1;
      snapshot    <= 16'h0000;
      frame_busy  <= 1'b0;
      scan_wrap   <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      if (start) begin
        state       <= LOAD;
        digit_idx   <= next_idx;
        first_frame <= 1'b0;
        frame_busy  <= 1'b1;
        // Only digit-0 frames resample so a whole scan shows one coherent value.
        if (next_idx == 2'd0) begin
          snapshot <= digits;
        end
      end else begin
        case (state)
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (shift_done) begin
              state     <= LATCH;
              scan_wrap <= (digit_idx == 2'd3);
            end
          end
          LATCH: begin
            state      <= IDLE;
            frame_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  seg_shift16 u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (state == LOAD),
    .word  (word),
    .sdata (seg_data),
    .latch (seg_latch),
    .done  (shift_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: directed bench for the seven-segment scan controller (REFRESH_DIV = 20).
// Revision: 1.0
`default_nettype none

module tb_seg_scan_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic        seg_data;
  logic        seg_latch;
  logic        frame_busy;
  logic [1:0]  digit_idx;
  logic        scan_wrap;

  int total;
  int bad;
  int edges;

  seg_scan_scheduler #(.REFRESH_DIV(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .seg_data   (seg_data),
    .seg_latch  (seg_latch),
    .frame_busy (frame_busy),
    .digit_idx  (digit_idx),
    .scan_wrap  (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Captures one frame starting from the LOAD cycle; optionally drops en at shift bit drop_at.
  task automatic get_frame(input string tag, input logic [15:0] exp_word, input logic [1:0] exp_idx,
                           input logic exp_wrap, input int drop_at, output int t_load);
    logic [15:0] w;
    logic [1:0]  idx;
    int          n;
    int          busy_n;
    int          stray;
    n = 0;
    while (frame_busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_timeout"}, 32'(n < 200), 32'd1);
    t_load = edges;
    idx    = digit_idx;
    busy_n = 1;
    stray  = int'(seg_latch) + int'(scan_wrap) + int'(seg_data);
    w      = '0;
    for (int k = 15; k >= 0; k--) begin
      @(negedge clk);
      if (k == drop_at) en = 1'b0;
      w[k]   = seg_data;
      busy_n = busy_n + int'(frame_busy);
      stray  = stray + int'(seg_latch) + int'(scan_wrap);
    end
    @(negedge clk);
    busy_n = busy_n + int'(frame_busy);
    check({tag, "_latch"}, {31'd0, seg_latch}, 32'd1);
    check({tag, "_wrap"}, {31'd0, scan_wrap}, {31'd0, exp_wrap});
    check({tag, "_data_in_latch"}, {31'd0, seg_data}, 32'd0);
    @(negedge clk);
    check({tag, "_after"}, {29'd0, frame_busy, seg_latch, scan_wrap}, 32'd0);
    check({tag, "_word"}, {16'd0, w}, {16'd0, exp_word});
    check({tag, "_idx"}, {30'd0, idx}, {30'd0, exp_idx});
    check({tag, "_busy_len"}, busy_n, 32'd18);
    check({tag, "_stray"}, stray, 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    int e0;
    int cnt;
    int n;
    total  = 0;
    bad    = 0;
    edges  = 0;
    rst    = 1'b1;
    en     = 1'b1;
    digits = 16'h1234;

    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, seg_data, seg_latch, frame_busy, digit_idx, scan_wrap}, 32'd0);
    rst   = 1'b0;
    edges = 0;

    get_frame("s0_d0", 16'h9901, 2'd0, 1'b0, -1, t0);
    check("first_load_cycle", t0 - 1, 32'd19);
    get_frame("s0_d1", 16'hB002, 2'd1, 1'b0, -1, t1);
    check("frame_period", t1 - t0, 32'd20);
    digits = 16'h5678;
    get_frame("s0_d2", 16'hA404, 2'd2, 1'b0, -1, t0);
    get_frame("s0_d3", 16'hF908, 2'd3, 1'b1, -1, t1);
    check("frame_period2", t1 - t0, 32'd20);
    get_frame("s1_d0", 16'h8001, 2'd0, 1'b0, -1, t0);

    get_frame("s1_d1_drop", 16'hF802, 2'd1, 1'b0, 8, t0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      cnt = cnt + int'(frame_busy) + int'(seg_latch);
    end
    check("disabled_quiet", cnt, 32'd0);
    en = 1'b1;
    e0 = edges;
    get_frame("s1_d2_resume", 16'h8204, 2'd2, 1'b0, -1, t0);
    check("resume_delay", t0 - e0, 32'd20);

    n = 0;
    while (frame_busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_start_timeout", 32'(n < 200), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, seg_data, seg_latch, frame_busy, digit_idx, scan_wrap}, 32'd0);
    digits = 16'h0007;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt = cnt + int'(seg_latch) + int'(frame_busy);
    end
    check("reset_no_latch", cnt, 32'd0);
    rst   = 1'b0;
    edges = 0;

    get_frame("z_d0", 16'hF801, 2'd0, 1'b0, -1, t0);
    check("restart_load_cycle", t0 - 1, 32'd19);
`ifdef SEG_BLANK_LEADING_ZERO_EN
    get_frame("z_d1", 16'hFF02, 2'd1, 1'b0, -1, t0);
    get_frame("z_d2", 16'hFF04, 2'd2, 1'b0, -1, t0);
    get_frame("z_d3", 16'hFF08, 2'd3, 1'b1, -1, t0);
`else
    get_frame("z_d1", 16'hC002, 2'd1, 1'b0, -1, t0);
    get_frame("z_d2", 16'hC004, 2'd2, 1'b0, -1, t0);
    get_frame("z_d3", 16'hC008, 2'd3, 1'b1, -1, t0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
